// File: rtl/slink_apb4_tgt_if.sv
// slink_apb4_tgt_if: APB4 bus between an APB master and the S-Link APB tunnel target.
interface slink_apb4_tgt_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [31:0]           pwdata;
    logic [3:0]            pstrb;
    logic [2:0]            pprot;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/slink_apb4_tgt.sv
// slink_apb4_tgt: tunnels APB4 transfers over S-Link as tagged request/response packets.
// Optional response timeout enabled by defining SLINK_APB4_TGT_TIMEOUT_EN.
module slink_apb4_tgt #(
    parameter int          ADDR_WIDTH       = 32,
    parameter logic [7:0]  APB_READ_DT      = 8'h30,
    parameter logic [7:0]  APB_READ_RSP_DT  = 8'h31,
    parameter logic [7:0]  APB_WRITE_DT     = 8'h32,
    parameter logic [7:0]  APB_WRITE_RSP_DT = 8'h33,
    parameter int          TIMEOUT_CYCLES   = 1024
) (
    input  logic                   apb_clk,
    input  logic                   apb_reset,
    slink_apb4_tgt_if.slave        apb,
    input  logic                   enable,
    output logic                   a2l_valid,
    input  logic                   a2l_ready,
    output logic [ADDR_WIDTH+71:0] a2l_data,
    input  logic                   l2a_valid,
    output logic                   l2a_accept,
    input  logic [71:0]            l2a_data,
    output logic [7:0]             drop_count,
    output logic                   timeout_seen,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            pstrb_q;
    logic [2:0]            pprot_q;
    logic                  pwrite_q, dis_q;
    logic [7:0]            tag_q;
    logic [1:0]            en_q;
    logic                  enable_sync, setup, hit, take, abort, tmo_hit;
    logic [7:0]            rsp_dt;
    logic [15:0]           wc;
    logic                  unused;

    assign enable_sync = en_q[1];
    assign setup       = apb.psel && !apb.penable;
    assign rsp_dt      = pwrite_q ? APB_WRITE_RSP_DT : APB_READ_RSP_DT;
    assign hit         = l2a_valid && l2a_data[7:0] == rsp_dt && l2a_data[71:64] == tag_q;
    // dis_q keeps a disabled access on the error path even if enable returns mid-flight
    assign abort       = !enable_sync || dis_q || tmo_hit;
    assign take        = state == WAIT_RSP && !abort && hit;
    assign wc          = 16'(ADDR_WIDTH / 8 + (pwrite_q ? 6 : 2));
    assign a2l_data    = {pwrite_q ? wdata_q : 32'h0, tag_q, 1'b0, pprot_q, pstrb_q, addr_q, wc,
                          pwrite_q ? APB_WRITE_DT : APB_READ_DT};
    assign a2l_valid   = state == REQ;
    assign l2a_accept  = l2a_valid;
    assign busy        = state != IDLE;
    assign unused      = ^{l2a_data[63:57], l2a_data[23:8]};

    always_ff @(posedge apb_clk or posedge apb_reset)
        if (apb_reset) state <= IDLE;
        else           state <= state_n;

    // A disabled access passes through WAIT_RSP so its error completion lands one cycle later
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     state_n = setup ? (enable_sync ? REQ : WAIT_RSP) : IDLE;
            REQ:      state_n = abort ? RESP : (a2l_ready ? WAIT_RSP : REQ);
            WAIT_RSP: state_n = (abort || hit) ? RESP : WAIT_RSP;
            RESP:     state_n = IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or posedge apb_reset)
        if (apb_reset) begin
            en_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            dis_q       <= 1'b0;
            tag_q       <= '0;
            drop_count  <= '0;
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
        end else begin
            en_q       <= {en_q[0], enable};
            apb.pready <= state_n == RESP;
            if (state == IDLE && setup) begin
                addr_q   <= apb.paddr;
                wdata_q  <= apb.pwdata;
                pstrb_q  <= apb.pstrb;
                pprot_q  <= apb.pprot;
                pwrite_q <= apb.pwrite;
                dis_q    <= !enable_sync;
            end
            if (state_n == RESP) begin
                apb.prdata  <= (take && !pwrite_q) ? l2a_data[55:24] : 32'h0;
                apb.pslverr <= take ? l2a_data[56] : 1'b1;
            end
            if (state == RESP) tag_q <= tag_q + 8'd1;
            if (l2a_valid && !take && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end

`ifdef SLINK_APB4_TGT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_cnt;

    assign tmo_hit = (state == REQ || state == WAIT_RSP) && tmo_cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge apb_clk or posedge apb_reset)
        if (apb_reset) begin
            tmo_cnt      <= '0;
            timeout_seen <= 1'b0;
        end else begin
            tmo_cnt      <= (state == REQ || state == WAIT_RSP) ? tmo_cnt + 1'b1 : '0;
            timeout_seen <= timeout_seen | tmo_hit;
        end
`else
    logic unused_tmo;
    assign unused_tmo   = TIMEOUT_CYCLES[0];
    assign tmo_hit      = 1'b0;
    assign timeout_seen = 1'b0;
`endif
endmodule

// File: doc/slink_apb4_tgt.md
# slink_apb4_tgt

APB4 target that tunnels each APB transfer over S-Link as a tagged request packet and completes the APB access when the matching tagged response packet returns. Second-generation APB tunnel: parametrised address width, carries PSTRB/PPROT, tags requests so stale or foreign responses are discarded, and errors out on disable or timeout instead of hanging the bus. It sits in the apb_clk domain between the APB master and a `slink_generic_fc_sm` instance, which the wrapper instantiates.

## Interface
- ADDR_WIDTH, 32, APB address width; multiple of 8, range 8..64
- APB_READ_DT / APB_READ_RSP_DT / APB_WRITE_DT / APB_WRITE_RSP_DT, 8'h30/8'h31/8'h32/8'h33, packet data IDs
- TIMEOUT_CYCLES, 1024, response timeout in apb_clk cycles, ≥2
- apb_clk  in  1  clock
- apb_reset  in  1  asynchronous, active-high reset
- apb_paddr  in  ADDR_WIDTH; apb_pwrite, apb_psel, apb_penable  in  1; apb_pwdata  in  32; apb_pstrb  in  4; apb_pprot  in  3
- apb_prdata  out  32; apb_pready, apb_pslverr  out  1, all registered
- enable  in  1  asynchronous; 2-flop synchronised internally
- a2l_valid  out  1; a2l_ready  in  1; a2l_data  out  ADDR_WIDTH+72  request packet {payload, WC[15:0], DT[7:0]}
- l2a_valid  in  1; l2a_accept  out  1; l2a_data  in  72  response packet
- drop_count  out  8  saturating count of discarded response packets
- timeout_seen  out  1  sticky, cleared by reset only
- busy  out  1  state != IDLE

## Operation
- Request layout, base bit 24: addr [24+:AW]; ctrl [24+AW+:8] = {1'b0, pprot, pstrb}; tag [32+AW+:8]; wdata [40+AW+:32].
- Read: DT=APB_READ_DT, WC=AW/8+2, wdata field 0. Write: DT=APB_WRITE_DT, WC=AW/8+6.
- Response layout: DT [7:0]; rdata [24+:32] (ignored for writes); status [56+:8], bit0 = slverr; tag [64+:8].
- tag_q: 8-bit counter, reset 0, increments on every RESP→IDLE and wraps 255→0.
- States:
  - IDLE: on psel&~penable, latch addr/wdata/pstrb/pprot/pwrite. If enable_sync is 1, go to REQ. Otherwise go to RESP with pslverr=1 and prdata=0.
  - REQ: a2l_valid=1 and a2l_data come from latched registers and stay stable until a2l_ready. On a2l_valid&a2l_ready, go to WAIT_RSP.
  - WAIT_RSP: a response matches if its DT equals the expected RSP DT for the latched pwrite and its tag equals tag_q. On a match, capture rdata and status[0], then go to RESP. A non-match is discarded.
  - RESP: apb_pready=1 for exactly one cycle with the captured prdata/pslverr, then IDLE.
- l2a_accept = l2a_valid in every state. Packets arriving outside WAIT_RSP, or non-matching packets, are discarded and drop_count increments, saturating at 255.
- If enable_sync falls while in REQ or WAIT_RSP, go to RESP with pslverr=1 and prdata=0. An a2l transfer that completes in that same cycle is still counted as sent.
- Write responses drive prdata=0.

## Timing
- Reset values: state IDLE; a2l_valid, l2a_accept (combinational with l2a_valid=0 is fine), apb_pready, apb_pslverr, timeout_seen = 0; apb_prdata 0; drop_count 0; tag_q 0.
- Setup cycle T: state latched. REQ from T+1, so a2l_valid is first seen at T+1.
- Matching response accepted in cycle N gives pready=1 in cycle N+1. Minimum transfer (a2l_ready=1, response in the first WAIT_RSP cycle) gives pready at T+3.
- Disabled path: pready at T+2.
- enable to enable_sync latency: 2 cycles.
- Reset mid-transfer returns to IDLE with no pready. The master must be reset too.

## Configuration
- SLINK_APB4_TGT_TIMEOUT_EN defined:
  - A counter clears on entering REQ and counts every cycle in REQ and WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES-1: go to RESP with pslverr=1, prdata=0, and set timeout_seen.
  - Any response that arrives later carries a stale tag and is discarded.
- Not defined: no counter, the block waits indefinitely, and timeout_seen is tied 0.

## Test plan
- Read: paddr=0x1000_0040, a2l_ready=1 → a2l_data DT=0x30, WC=6, tag=0x00. Response DT=0x31, tag=0x00, rdata=0xDEADBEEF, status=0 → pready at T+3, prdata=0xDEADBEEF, pslverr=0.
- Write: pwdata=0x12345678, pstrb=4'b0101, pprot=3'b010 → WC=10, ctrl=0x25, tag=0x01. Response DT=0x33, status=1 → pslverr=1, prdata=0.
- Stale/foreign: in WAIT_RSP inject tag=0x05 and then DT=0x33 on a read → both discarded, drop_count=2, no pready. A correct response then completes the transfer.
- Backpressure: a2l_ready=0 for 10 cycles → a2l_data is stable throughout, no pready. Transfer completes after ready.
- Disable: enable=0 → next access gets pready at T+2 with pslverr=1 and no a2l_valid. Dropping enable during WAIT_RSP → error completion.
- Timeout (macro on, TIMEOUT_CYCLES=16): no response → pslverr=1, timeout_seen=1. Late response afterwards → drop_count+1. tag wraps 0xFF→0x00 after 256 transfers.
